// File: rtl/ps2_host_tx_if.sv
// Command handshake and frame status between a host controller and the PS/2 transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       rx_inhibit;
  logic       done;
  logic       ack_ok;
  logic       error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, rx_inhibit, done, ack_ok, error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, rx_inhibit, done, ack_ok, error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits, requests to send, clocks out one
// command byte on device clock falls, and checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned REQ_CYCLES     = 25,
  parameter int unsigned TIMEOUT_CYCLES = 375000,
  parameter int unsigned FILTER_CYCLES  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe,
  ps2_host_tx_if.slave  bus
);

  localparam int unsigned PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FL_W   = $clog2(FILTER_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_XFER,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_clk_filt, r_clk_filt_d;
  logic [FL_W-1:0] r_filt_cnt;
  logic            w_fall;

  state_t          r_state;
  logic [PH_W-1:0] r_ph_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic [3:0]      r_bit;
  logic [7:0]      r_data;
  logic            r_parity;
  logic            r_clk_oe, r_data_oe;
  logic            r_tx_ready, r_busy, r_done, r_ack_ok, r_error;

  // Synchronizers plus a stability filter on the clock; idle lines read as high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1     <= 1'b1;
      r_clk_s2     <= 1'b1;
      r_dat_s1     <= 1'b1;
      r_dat_s2     <= 1'b1;
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_s1     <= ps2_clk_i;
      r_clk_s2     <= r_clk_s1;
      r_dat_s1     <= ps2_data_i;
      r_dat_s2     <= r_dat_s1;
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FL_W'(FILTER_CYCLES - 1)) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FL_W'(1);
      end
    end
  end

  assign w_fall = r_clk_filt_d & ~r_clk_filt;

  // Frame sequencer; a timeout in XFER/WAIT_IDLE abandons the frame with error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ph_cnt   <= '0;
      r_to_cnt   <= '0;
      r_bit      <= '0;
      r_data     <= '0;
      r_parity   <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_tx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ack_ok   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clk_oe   <= 1'b0;
          r_data_oe  <= 1'b0;
          r_tx_ready <= 1'b1;
          if (bus.tx_valid && r_tx_ready) begin
            r_data     <= bus.tx_data;
            r_parity   <= ~^bus.tx_data;
            r_ack_ok   <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b1;
            r_tx_ready <= 1'b0;
            r_ph_cnt   <= '0;
            r_clk_oe   <= 1'b1;
            r_state    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_ph_cnt == PH_W'(INHIBIT_CYCLES - 1)) begin
            r_ph_cnt  <= '0;
            r_data_oe <= 1'b1;
            r_state   <= S_REQ;
          end else begin
            r_ph_cnt <= r_ph_cnt + PH_W'(1);
          end
        end
        S_REQ: begin
          if (r_ph_cnt == PH_W'(REQ_CYCLES - 1)) begin
            r_ph_cnt <= '0;
            r_clk_oe <= 1'b0;
            r_bit    <= '0;
            r_to_cnt <= '0;
            r_state  <= S_XFER;
          end else begin
            r_ph_cnt <= r_ph_cnt + PH_W'(1);
          end
        end
        S_XFER: begin
          if (w_fall) begin
            r_to_cnt <= '0;
            r_bit    <= r_bit + 4'd1;
            if (r_bit < 4'd8) begin
              r_data_oe <= ~r_data[r_bit[2:0]];
            end else if (r_bit == 4'd8) begin
              r_data_oe <= ~r_parity;
            end else if (r_bit == 4'd9) begin
              r_data_oe <= 1'b0;
            end else begin
              // Eleventh fall: device drives data low to acknowledge.
              if (r_dat_s2) r_error  <= 1'b1;
              else          r_ack_ok <= 1'b1;
              r_state <= S_WAIT_IDLE;
            end
          end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_error   <= 1'b1;
            r_ack_ok  <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        S_WAIT_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          if (r_clk_filt && r_dat_s2) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_fall) begin
            r_to_cnt <= '0;
          end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            r_error  <= 1'b1;
            r_ack_ok <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        S_DONE: begin
          r_busy     <= 1'b0;
          r_tx_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ps2_clk_oe     = r_clk_oe;
  assign ps2_data_oe    = r_data_oe;
  assign bus.tx_ready   = r_tx_ready;
  assign bus.busy       = r_busy;
  assign bus.rx_inhibit = r_busy;
  assign bus.done       = r_done;
  assign bus.ack_ok     = r_ack_ok;
  assign bus.error      = r_error;

endmodule
